sync_fifo_top: RTL and testbench

Single-clock, parametrised synchronous FIFO. It is the next-generation companion to the dual-clock FIFO and is used where producer and consumer share one clock domain. Beyond plain full/empty it adds:
- a fill count
- programmable almost-full / almost-empty thresholds
- sticky overflow/underflow error flags
- simultaneous push/pop when full

---
 rtl/sync_fifo_pkg.sv | 31 +++
 rtl/sync_fifo_mem.sv | 46 ++++
 rtl/sync_fifo_top.sv | 153 +++++++++++++++
 tb/tb_sync_fifo_top.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants, width helper and status bundle for the
// single-clock FIFO.
package sync_fifo_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_DWIDTH = 8;

    // Ceiling log2, used to cross-check DEPTH against PTRWIDTH.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Flag snapshot, handy for monitors and benches to compare in one go.
    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: storage array with one write port and one read port.
// Config macro SYNC_FIFO_FWFT_EN: when defined the read port is a
// combinational head read; otherwise it is a registered read cleared by reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PTRWIDTH = 4,
    parameter int DWIDTH   = DEF_DWIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [PTRWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0]   wdata,
    input  logic                re,
    input  logic [PTRWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0]   rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Write port; contents are never reset, the pointers make stale data invisible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is always visible; the read enable and reset are not needed.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = re ^ reset;
    assign rdata = mem[raddr];
`else
    // Registered read: capture the addressed entry on an accepted pop, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_top.sv
// sync_fifo_top: single-clock FIFO with fill count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and push+pop while full.
// Config macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads;
// the default build uses a 1-cycle registered read.
module sync_fifo_top
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int PTRWIDTH  = 4,
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [DWIDTH-1:0]   wdata,
    output logic                full,
    output logic                almost_full,
    input  logic                pop,
    output logic [DWIDTH-1:0]   rdata,
    output logic                rvalid,
    output logic                empty,
    output logic                almost_empty,
    output logic [PTRWIDTH:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                clr_err
);

    // Pointer arithmetic relies on DEPTH being an exact power of two.
    if (clog2(DEPTH) != PTRWIDTH || DEPTH != (1 << PTRWIDTH)) begin : g_bad_depth
        $error("sync_fifo_top: DEPTH must equal 2**PTRWIDTH");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_top: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_top: AE_THRESH out of range 0..DEPTH-1");
    end

    localparam logic [PTRWIDTH:0] FULL_LVL = (PTRWIDTH+1)'(DEPTH);
    localparam logic [PTRWIDTH:0] AF_LVL   = (PTRWIDTH+1)'(AF_THRESH);
    localparam logic [PTRWIDTH:0] AE_LVL   = (PTRWIDTH+1)'(AE_THRESH);

    logic [PTRWIDTH-1:0] wptr;
    logic [PTRWIDTH-1:0] rptr;
    logic [PTRWIDTH:0]   count_q;
    logic [PTRWIDTH:0]   count_next;
    logic                full_q;
    logic                almost_full_q;
    logic                empty_q;
    logic                almost_empty_q;
    logic                overflow_q;
    logic                underflow_q;
    logic                push_acc;
    logic                pop_acc;
    logic [DWIDTH-1:0]   mem_rdata;

    // A pop frees a slot this same edge, so a full FIFO may still accept a push.
    assign pop_acc  = pop && !empty_q;
    assign push_acc = push && (!full_q || pop_acc);

    // Next occupancy; flags are derived from this so they never lag count.
    always_comb begin
        count_next = count_q;
        if (push_acc && !pop_acc) begin
            count_next = count_q + 1'b1;
        end else if (pop_acc && !push_acc) begin
            count_next = count_q - 1'b1;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr           <= '0;
            rptr           <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
        end else begin
            if (push_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_acc) begin
                rptr <= rptr + 1'b1;
            end
            count_q        <= count_next;
            full_q         <= (count_next == FULL_LVL);
            almost_full_q  <= (count_next >= AF_LVL);
            empty_q        <= (count_next == '0);
            almost_empty_q <= (count_next <= AE_LVL);
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (overflow_q  && !clr_err) || (push && !push_acc);
            underflow_q <= (underflow_q && !clr_err) || (pop  && !pop_acc);
        end
    end

    sync_fifo_mem #(
        .DEPTH    (DEPTH),
        .PTRWIDTH (PTRWIDTH),
        .DWIDTH   (DWIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push_acc),
        .waddr (wptr),
        .wdata (wdata),
        .re    (pop_acc),
        .raddr (rptr),
        .rdata (mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented whenever the FIFO holds data; blank when empty.
    assign rdata  = empty_q ? '0 : mem_rdata;
    assign rvalid = !empty_q;
`else
    logic rvalid_q;

    // rvalid marks the cycle in which a freshly popped word sits on rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= pop_acc;
        end
    end

    assign rdata  = mem_rdata;
    assign rvalid = rvalid_q;
`endif

    assign count        = count_q;
    assign full         = full_q;
    assign almost_full  = almost_full_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_top.sv
// tb_sync_fifo_top: directed bench for sync_fifo_top (DEPTH=16, DWIDTH=8,
// AF_THRESH=14, AE_THRESH=2). Follows SYNC_FIFO_FWFT_EN to pick the read mode.
module tb_sync_fifo_top;
    import sync_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [7:0] wdata;
    logic       full;
    logic       almost_full;
    logic       pop;
    logic [7:0] rdata;
    logic       rvalid;
    logic       empty;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int checkCount = 0;
    int failCount  = 0;

    sync_fifo_top #(
        .DEPTH     (16),
        .PTRWIDTH  (4),
        .DWIDTH    (8),
        .AF_THRESH (14),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .wdata        (wdata),
        .full         (full),
        .almost_full  (almost_full),
        .pop          (pop),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then settle just past the edge.
    task automatic applyStimulus(input logic p, input logic [7:0] d, input logic po,
                                 input logic c, input logic r);
        push    = p;
        wdata   = d;
        pop     = po;
        clr_err = c;
        reset   = r;
        @(posedge clk);
        #1;
    endtask

    // Compare all six status flags at once through the package status bundle.
    task automatic checkFlags(input string tag, input logic f, input logic af,
                              input logic e, input logic ae, input logic ov,
                              input logic un);
        fifo_status_t got;
        fifo_status_t exp;
        got = '{full, almost_full, empty, almost_empty, overflow, underflow};
        exp = '{f, af, e, ae, ov, un};
        checkOutput(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        push = 0; wdata = 0; pop = 0; clr_err = 0; reset = 1;
        applyStimulus(0, 8'h00, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 1);

        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'd0);
        checkFlags("rst_flags", 0, 0, 1, 1, 0, 0);

`ifdef SYNC_FIFO_FWFT_EN
        // Word pushed into an empty FIFO falls through on the next cycle.
        applyStimulus(1, 8'h3C, 0, 0, 0);
        checkOutput("fwft_rdata", 32'(rdata), 32'h3C);
        checkOutput("fwft_rvalid", 32'(rvalid), 32'd1);
        checkOutput("fwft_count", 32'(count), 32'd1);
        checkFlags("fwft_flags", 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("fwft_pop_rvalid", 32'(rvalid), 32'd0);
        checkFlags("fwft_pop_flags", 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 8'h5A, 0, 0, 0);
        applyStimulus(1, 8'h6B, 0, 0, 0);
        checkOutput("fwft_head1", 32'(rdata), 32'h5A);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("fwft_head2", 32'(rdata), 32'h6B);
        checkOutput("fwft_cnt2", 32'(count), 32'd1);
        applyStimulus(0, 8'h00, 1, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkFlags("fwft_unf", 0, 0, 1, 1, 0, 1);
        checkOutput("fwft_empty_rv", 32'(rvalid), 32'd0);
`else
        // Fill 0x00..0x0F; almost_full first rises at count 14.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 8'(i), 0, 0, 0);
            checkOutput("fill_count", 32'(count), 32'(i + 1));
            checkFlags("fill_flags", (i + 1) == 16, (i + 1) >= 14, 1'b0,
                       (i + 1) <= 2, 1'b0, 1'b0);
        end

        // Push+pop while full: count holds, data streams out in order across the wrap.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 8'(16 + k), 1, 0, 0);
            checkOutput("pp_rdata", 32'(rdata), 32'(k));
            checkOutput("pp_rvalid", 32'(rvalid), 32'd1);
            checkOutput("pp_count", 32'(count), 32'd16);
            checkFlags("pp_flags", 1, 1, 0, 0, 0, 0);
        end

        // Push alone when full is rejected; a clear in an erroring cycle loses.
        applyStimulus(1, 8'hEE, 0, 0, 0);
        checkOutput("ovf_count", 32'(count), 32'd16);
        checkOutput("ovf_rvalid", 32'(rvalid), 32'd0);
        checkOutput("ovf_rdata_hold", 32'(rdata), 32'd19);
        checkFlags("ovf_flags", 1, 1, 0, 0, 1, 0);
        applyStimulus(1, 8'hEE, 0, 1, 0);
        checkFlags("ovf_setwins", 1, 1, 0, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkFlags("ovf_clr", 1, 1, 0, 0, 0, 0);

        // Drain: remaining words are 20..35.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 8'h00, 1, 0, 0);
            checkOutput("drain_rdata", 32'(rdata), 32'(20 + k));
            checkOutput("drain_count", 32'(count), 32'(15 - k));
            checkFlags("drain_flags", 1'b0, (15 - k) >= 14, (15 - k) == 0,
                       (15 - k) <= 2, 1'b0, 1'b0);
        end
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("idle_rvalid", 32'(rvalid), 32'd0);
        checkOutput("idle_rdata", 32'(rdata), 32'h23);

        // Empty with push+pop: push lands, pop is rejected.
        applyStimulus(1, 8'hA5, 1, 0, 0);
        checkOutput("ep_count", 32'(count), 32'd1);
        checkOutput("ep_rvalid", 32'(rvalid), 32'd0);
        checkFlags("ep_flags", 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkFlags("unf_clr", 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("ep_rdata", 32'(rdata), 32'hA5);
        checkOutput("ep_rvalid2", 32'(rvalid), 32'd1);
        checkOutput("ep_count2", 32'(count), 32'd0);

        // Reset mid-stream with a push pending.
        applyStimulus(1, 8'h11, 0, 0, 0);
        applyStimulus(1, 8'h22, 0, 0, 0);
        checkOutput("pre_rst_count", 32'(count), 32'd2);
        applyStimulus(1, 8'h33, 0, 0, 1);
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("mid_rst_rdata", 32'(rdata), 32'd0);
        checkFlags("mid_rst_flags", 0, 0, 1, 1, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkFlags("post_rst_unf", 0, 0, 1, 1, 0, 1);
        checkOutput("post_rst_rvalid", 32'(rvalid), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
